// File: rtl/hci_parity_source_tracked_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hci_core_intf : HCI core channel bundle (request, response and ECC handshake)
// Rev 1.0
// ----------------------------------------------------------------------------
interface hci_core_intf #(
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32,
  parameter int unsigned BEW = 4,
  parameter int unsigned UW  = 2,
  parameter int unsigned IW  = 4,
  parameter int unsigned EW  = 7,
  parameter int unsigned EHW = 1
) ();
  logic           req;
  logic           gnt;
  logic [AW-1:0]  add;
  logic           wen;
  logic [DW-1:0]  data;
  logic [BEW-1:0] be;
  logic           r_ready;
  logic [UW-1:0]  user;
  logic [IW-1:0]  id;
  logic [DW-1:0]  r_data;
  logic           r_valid;
  logic [UW-1:0]  r_user;
  logic [IW-1:0]  r_id;
  logic           r_opc;
  logic [EHW-1:0] ereq;
  logic [EHW-1:0] egnt;
  logic [EHW-1:0] r_evalid;
  logic           r_eready;
  logic [EW-1:0]  ecc;
  logic [EW-1:0]  r_ecc;

  // r_eready is returned by the sink side so the source can cross-check it.
  modport initiator (
    output req, add, wen, data, be, r_ready, user, id, ereq, ecc,
    input  gnt, r_data, r_valid, r_user, r_id, r_opc, egnt, r_evalid, r_eready, r_ecc
  );

  modport target (
    input  req, add, wen, data, be, r_ready, user, id, ereq, ecc,
    output gnt, r_data, r_valid, r_user, r_id, r_opc, egnt, r_evalid, r_eready, r_ecc
  );

  modport monitor (
    input req, gnt, add, wen, data, be, r_ready, user, id, r_data, r_valid, r_user,
          r_id, r_opc, ereq, egnt, r_evalid, r_eready, ecc, r_ecc
  );
endinterface
`default_nettype wire

// File: rtl/hci_parity_source_tracked.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hci_parity_source_tracked : per-channel HCI parity generation with
// return-path cross-check, sticky/first-fault capture and fault counter.
// Rev 1.0
// ----------------------------------------------------------------------------
module hci_parity_source_tracked #(
  parameter int unsigned N_CH        = 1,
  parameter int unsigned DW          = 32,
  parameter int unsigned BW          = 8,
  parameter int unsigned AW          = 32,
  parameter bit          QUALIFY     = 1'b1,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned FAULT_DELAY = 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  hci_core_intf.monitor                         tcdm_main   [N_CH],
  hci_core_intf.initiator                       tcdm_parity [N_CH],
  input  logic                                  enable_i,
  input  logic                                  clear_i,
  output logic                                  fault_o,
  output logic [N_CH-1:0]                       fault_sticky_o,
  output logic                                  first_valid_o,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] first_ch_o,
  output logic [3:0]                            first_field_o,
  output logic [CNT_W-1:0]                      fault_cnt_o
);

  localparam int unsigned NL  = DW / BW;
  localparam int unsigned CHW = (N_CH > 1) ? $clog2(N_CH) : 1;

  function automatic logic [3:0] lowest_code(input logic [9:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 9; i >= 0; i--) begin
      if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

  logic [N_CH-1:0]       hit_w;
  logic [N_CH-1:0][3:0]  code_w;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [AW-1:0] add_w;
    logic [NL-1:0] dpar_w;
    logic [NL-1:0] rpar_w;
    logic [9:0]    mm_w;

    assign add_w = tcdm_main[c].add;

    always_comb begin
      dpar_w = '0;
      rpar_w = '0;
      for (int i = 0; i < NL; i++) begin
        dpar_w[i] = ^tcdm_main[c].data[i*BW +: BW];
        rpar_w[i] = ^tcdm_main[c].r_data[i*BW +: BW];
      end
    end

    assign tcdm_parity[c].req     = tcdm_main[c].req;
    assign tcdm_parity[c].wen     = tcdm_main[c].wen;
    assign tcdm_parity[c].be      = tcdm_main[c].be;
    assign tcdm_parity[c].r_ready = tcdm_main[c].r_ready;
    assign tcdm_parity[c].user    = tcdm_main[c].user;
    assign tcdm_parity[c].id      = tcdm_main[c].id;
    assign tcdm_parity[c].add     = ^add_w;
    assign tcdm_parity[c].data    = dpar_w;
    assign tcdm_parity[c].ereq    = ^tcdm_main[c].ereq;
    assign tcdm_parity[c].ecc     = ^tcdm_main[c].ecc;

    // Bit index of mm_w is the field code reported on first_field_o.
    always_comb begin
      mm_w    = '0;
      mm_w[0] = tcdm_main[c].gnt      != tcdm_parity[c].gnt;
      mm_w[1] = tcdm_main[c].r_valid  != tcdm_parity[c].r_valid;
      mm_w[2] = rpar_w                != tcdm_parity[c].r_data;
      mm_w[3] = tcdm_main[c].r_id     != tcdm_parity[c].r_id;
      mm_w[4] = tcdm_main[c].r_user   != tcdm_parity[c].r_user;
      mm_w[5] = tcdm_main[c].r_opc    != tcdm_parity[c].r_opc;
      mm_w[6] = (^tcdm_main[c].egnt)     != (^tcdm_parity[c].egnt);
      mm_w[7] = (^tcdm_main[c].r_evalid) != (^tcdm_parity[c].r_evalid);
      mm_w[8] = tcdm_main[c].r_eready != tcdm_parity[c].r_eready;
      mm_w[9] = (^tcdm_main[c].r_ecc)    != (^tcdm_parity[c].r_ecc);
      if (QUALIFY && !tcdm_main[c].r_valid) mm_w[5:2] = '0;
      if (!enable_i) mm_w = '0;
    end

    assign hit_w[c]  = |mm_w;
    assign code_w[c] = lowest_code(mm_w);
  end

  logic [FAULT_DELAY-1:0][N_CH-1:0]      hit_q,  hit_d;
  logic [FAULT_DELAY-1:0][N_CH-1:0][3:0] code_q, code_d;

  always_comb begin
    hit_d     = hit_q;
    code_d    = code_q;
    hit_d[0]  = hit_w;
    code_d[0] = code_w;
    for (int s = 1; s < FAULT_DELAY; s++) begin
      hit_d[s]  = hit_q[s-1];
      code_d[s] = code_q[s-1];
    end
  end

  logic [N_CH-1:0]      cap_hit_w;
  logic [N_CH-1:0][3:0] cap_code_w;
  assign cap_hit_w  = hit_q[FAULT_DELAY-1];
  assign cap_code_w = code_q[FAULT_DELAY-1];

  logic             fault_q,       fault_d;
  logic [N_CH-1:0]  sticky_q,      sticky_d;
  logic             first_valid_q, first_valid_d;
  logic [CHW-1:0]   first_ch_q,    first_ch_d;
  logic [3:0]       first_field_q, first_field_d;
  logic [CNT_W-1:0] cnt_q,         cnt_d;
  logic [CNT_W-1:0] cnt_base_w;

  // Clear wipes the recorded state first; a fault arriving in the same cycle
  // is then recorded on top of the cleared state.
  always_comb begin
    fault_d       = |cap_hit_w;
    sticky_d      = (clear_i ? '0 : sticky_q) | cap_hit_w;
    first_valid_d = clear_i ? 1'b0 : first_valid_q;
    first_ch_d    = clear_i ? '0   : first_ch_q;
    first_field_d = clear_i ? 4'd0 : first_field_q;
    cnt_base_w    = clear_i ? '0   : cnt_q;
    cnt_d         = cnt_base_w;
    if (fault_d && !first_valid_d) begin
      first_valid_d = 1'b1;
      for (int c = N_CH - 1; c >= 0; c--) begin
        if (cap_hit_w[c]) begin
          first_ch_d    = CHW'(c);
          first_field_d = cap_code_w[c];
        end
      end
    end
    if (fault_d && (cnt_base_w != {CNT_W{1'b1}})) cnt_d = cnt_base_w + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_q         <= '0;
      code_q        <= '0;
      fault_q       <= 1'b0;
      sticky_q      <= '0;
      first_valid_q <= 1'b0;
      first_ch_q    <= '0;
      first_field_q <= 4'd0;
      cnt_q         <= '0;
    end else begin
      hit_q         <= hit_d;
      code_q        <= code_d;
      fault_q       <= fault_d;
      sticky_q      <= sticky_d;
      first_valid_q <= first_valid_d;
      first_ch_q    <= first_ch_d;
      first_field_q <= first_field_d;
      cnt_q         <= cnt_d;
    end
  end

  assign fault_o        = fault_q;
  assign fault_sticky_o = sticky_q;
  assign first_valid_o  = first_valid_q;
  assign first_ch_o     = first_ch_q;
  assign first_field_o  = first_field_q;
  assign fault_cnt_o    = cnt_q;

endmodule
`default_nettype wire
